// File: rtl/tagged_memory.sv
// rtl/tagged_memory.sv - 1M x 64-bit tagged main memory on a multiplexed address/data bus.
// Optional simulation bus-protocol checks enabled by defining TMEM_PROTOCOL_CHECK_EN.
module tagged_memory #(
   parameter int AW = 20,
   parameter int DW = 64,
   parameter int TW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] i_ad,
   input  logic [TW-1:0] i_tag,
   input  logic          i_astb,
   input  logic          i_atomic,
   input  logic          i_rd,
   input  logic          i_wr,
   output logic [DW-1:0] o_data,
   output logic [TW-1:0] o_tag
);

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [TW-1:0] tag [0:(1<<AW)-1];
   logic [AW-1:0] waddr;
   logic [AW-1:0] waddr_d;
   logic          lock_q, lock_d;
   logic [DW-1:0] o_data_q, o_data_d;
   logic [TW-1:0] o_tag_q, o_tag_d;
   logic [AW-1:0] ea;
   logic          wr_en;

   // A strobe cycle carries an address on the bus, so it can never also be a data write.
   always_comb begin
      ea       = i_astb ? i_ad[AW-1:0] : waddr;
      wr_en    = i_wr && !i_astb;
      waddr_d  = waddr;
      lock_d   = lock_q;
      o_data_d = o_data_q;
      o_tag_d  = o_tag_q;
      if (i_astb) begin
         waddr_d = i_ad[AW-1:0];
         lock_d  = i_atomic;
      end else if (wr_en) begin
         lock_d = 1'b0;
      end
      if (i_rd) begin
         o_data_d = mem[ea];
         o_tag_d  = tag[ea];
      end
   end

   // Array writes share the reset branch so a write is dropped on any edge that sees reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         waddr    <= '0;
         lock_q   <= 1'b0;
         o_data_q <= '0;
         o_tag_q  <= '0;
      end else begin
         waddr    <= waddr_d;
         lock_q   <= lock_d;
         o_data_q <= o_data_d;
         o_tag_q  <= o_tag_d;
         if (wr_en) begin
            mem[waddr] <= i_ad;
            tag[waddr] <= i_tag;
         end
      end
   end

   assign o_data = o_data_q;
   assign o_tag  = o_tag_q;

`ifdef TMEM_PROTOCOL_CHECK_EN
   logic seen_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seen_q <= 1'b0;
      end else begin
         if ($isunknown({i_astb, i_rd, i_wr}))
            $error("tagged_memory: X on bus control");
         if ((i_rd || i_wr) && !i_astb && !seen_q)
            $error("tagged_memory: access before first address strobe");
         if (i_astb && lock_q)
            $error("tagged_memory: strobe inside unfinished atomic sequence");
         if (i_astb && i_wr)
            $error("tagged_memory: strobe together with write");
         if (i_astb)
            seen_q <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_tagged_memory.sv
// tb/tb_tagged_memory.sv - directed vector table, reset sequences and randomized model check for tagged_memory.
module tb_tagged_memory;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] i_ad;
   logic [7:0]  i_tag;
   logic        i_astb, i_atomic, i_rd, i_wr;
   logic [63:0] o_data;
   logic [7:0]  o_tag;

   int n_tests = 0;
   int n_fail  = 0;

   tagged_memory dut (
      .clk(clk), .reset(reset), .i_ad(i_ad), .i_tag(i_tag), .i_astb(i_astb),
      .i_atomic(i_atomic), .i_rd(i_rd), .i_wr(i_wr), .o_data(o_data), .o_tag(o_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          astb;
      bit          atomic;
      bit          rd;
      bit          wr;
      logic [63:0] ad;
      logic [7:0]  tg;
      logic [63:0] e_data;
      logic [7:0]  e_tag;
      logic [19:0] e_waddr;
      bit          e_lock;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit astb, bit atomic, bit rd, bit wr, logic [63:0] ad, logic [7:0] tg,
                               logic [63:0] e_data, logic [7:0] e_tag, logic [19:0] e_waddr, bit e_lock);
      vec_t v;
      v.astb = astb; v.atomic = atomic; v.rd = rd; v.wr = wr; v.ad = ad; v.tg = tg;
      v.e_data = e_data; v.e_tag = e_tag; v.e_waddr = e_waddr; v.e_lock = e_lock;
      return v;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(bit astb, bit atomic, bit rd, bit wr, logic [63:0] ad, logic [7:0] tg);
      i_astb = astb; i_atomic = atomic; i_rd = rd; i_wr = wr; i_ad = ad; i_tag = tg;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(string name, logic [63:0] d, logic [7:0] t, logic [19:0] wa, bit lk);
      check({name, ".o_data"}, o_data, d);
      check({name, ".o_tag"}, 64'(o_tag), 64'(t));
      check({name, ".waddr"}, 64'(dut.waddr), 64'(wa));
      check({name, ".lock"}, 64'(dut.lock_q), 64'(lk));
   endtask

   logic [63:0] m_data [16];
   logic [7:0]  m_tag  [16];
   int          m_off;
   bit          m_lock;
   logic [63:0] e_data;
   logic [7:0]  e_tag;

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 0, 64'h0, 8'h0);
      step();
      step();
      check_all("reset", 64'h0, 8'h0, 20'h0, 1'b0);

      dut.mem[5] = 64'h0123456789abcdef; dut.tag[5] = 8'h34;
      dut.mem[7] = 64'h3;                dut.tag[7] = 8'h07;
      dut.mem[3] = 64'haaaa;             dut.tag[3] = 8'h33;
      dut.mem[9] = 64'h99;               dut.tag[9] = 8'h09;
      dut.mem[0] = 64'h1234;             dut.tag[0] = 8'h12;
      reset = 1'b0;

      vecs.push_back(mk(1, 0, 0, 0, 64'd5, 8'h00, 64'h0, 8'h00, 20'd5, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'h0123456789abcdef, 8'h34, 20'd5, 0));
      vecs.push_back(mk(1, 0, 0, 0, 64'h808c6, 8'h00, 64'h0123456789abcdef, 8'h34, 20'h808c6, 0));
      vecs.push_back(mk(0, 0, 0, 1, 64'hdeadbeef00000001, 8'h14, 64'h0123456789abcdef, 8'h34, 20'h808c6, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'hdeadbeef00000001, 8'h14, 20'h808c6, 0));
      vecs.push_back(mk(1, 0, 1, 0, 64'd5, 8'h00, 64'h0123456789abcdef, 8'h34, 20'd5, 0));
      vecs.push_back(mk(1, 1, 0, 0, 64'd7, 8'h00, 64'h0123456789abcdef, 8'h34, 20'd7, 1));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'h3, 8'h07, 20'd7, 1));
      vecs.push_back(mk(0, 0, 0, 1, 64'd4, 8'h08, 64'h3, 8'h07, 20'd7, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'h4, 8'h08, 20'd7, 0));
      vecs.push_back(mk(1, 0, 0, 0, 64'h0000_0000_0010_0003, 8'h00, 64'h4, 8'h08, 20'd3, 0));
      vecs.push_back(mk(0, 0, 1, 1, 64'h5555, 8'h55, 64'haaaa, 8'h33, 20'd3, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'h5555, 8'h55, 20'd3, 0));
      vecs.push_back(mk(1, 0, 0, 1, 64'd9, 8'hee, 64'h5555, 8'h55, 20'd9, 0));
      vecs.push_back(mk(0, 0, 1, 0, 64'd0, 8'h00, 64'h99, 8'h09, 20'd9, 0));
      vecs.push_back(mk(0, 0, 0, 0, 64'hffff, 8'hff, 64'h99, 8'h09, 20'd9, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].astb, vecs[i].atomic, vecs[i].rd, vecs[i].wr, vecs[i].ad, vecs[i].tg);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e_data, vecs[i].e_tag, vecs[i].e_waddr, vecs[i].e_lock);
      end

      // Asynchronous reset with a write pending: outputs clear at once, the write never lands.
      reset = 1'b1;
      drive(0, 0, 0, 1, 64'hbad, 8'hbb);
      #1;
      check_all("async_rst", 64'h0, 8'h0, 20'h0, 1'b0);
      step();
      reset = 1'b0;
      drive(1, 0, 1, 0, 64'd0, 8'h00);
      step();
      check_all("rst_mem0", 64'h1234, 8'h12, 20'd0, 1'b0);
      drive(1, 0, 1, 0, 64'd9, 8'h00);
      step();
      check_all("rst_mem9", 64'h99, 8'h09, 20'd9, 1'b0);
      drive(1, 0, 1, 0, 64'd5, 8'h00);
      step();
      check_all("rst_mem5", 64'h0123456789abcdef, 8'h34, 20'd5, 1'b0);

      for (int i = 0; i < 16; i++) begin
         m_data[i] = {$urandom, $urandom};
         m_tag[i]  = 8'($urandom);
         dut.mem[20'h100 + i] = m_data[i];
         dut.tag[20'h100 + i] = m_tag[i];
      end
      m_off  = 0;
      m_lock = 1'b0;
      e_data = 64'h0123456789abcdef;
      e_tag  = 8'h34;

      for (int k = 0; k < 300; k++) begin
         bit          astb, atomic, rd, wr;
         int          off, ea_off;
         logic [63:0] ad;
         logic [7:0]  tg;
         astb   = (k == 0) || ($urandom_range(0, 3) == 0);
         atomic = 1'($urandom_range(0, 1));
         rd     = 1'($urandom_range(0, 1));
         wr     = 1'($urandom_range(0, 1));
         off    = $urandom_range(0, 15);
         ad     = {$urandom, $urandom};
         tg     = 8'($urandom);
         if (astb) ad[19:0] = 20'h100 + 20'(off);
         ea_off = astb ? off : m_off;
         if (rd) begin
            e_data = m_data[ea_off];
            e_tag  = m_tag[ea_off];
         end
         if (wr && !astb) begin
            m_data[m_off] = ad;
            m_tag[m_off]  = tg;
         end
         if (astb) begin
            m_off  = off;
            m_lock = atomic;
         end else if (wr) begin
            m_lock = 1'b0;
         end
         drive(astb, atomic, rd, wr, ad, tg);
         step();
         check_all($sformatf("rnd%0d", k), e_data, e_tag, 20'h100 + 20'(m_off), m_lock);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
